sonar_sampler: RTL and testbench



---
 rtl/sonar_sampler.sv | 170 +++++++++++++++++
 tb/tb_sonar_sampler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sonar_sampler.sv
// sonar_sampler: periodic measure scheduler, ready-edge capture and moving average.
// Optional median-of-3 prefilter enabled by defining SONAR_SAMPLER_MEDIAN3_EN.
`timescale 1ns/1ps
module sonar_sampler #(
   parameter int  FREQ            = 50_000_000,
   parameter int  PERIOD_MS       = 60,
   parameter real RESP_TIMEOUT_MS = 50.0,
   parameter int  AVG_LOG2        = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   output logic       measure,
   input  logic       drv_ready,
   input  logic [7:0] drv_distance,
   output logic [7:0] last_distance,
   output logic [7:0] avg_distance,
   output logic       avg_valid,
   output logic       no_echo,
   output logic       fault
);

   localparam int PERIOD_CYC = FREQ / 1000 * PERIOD_MS;
   localparam int RESP_CYC   = $rtoi(FREQ / 1000 * RESP_TIMEOUT_MS);
   localparam int N          = 1 << AVG_LOG2;
   localparam int SW         = 8 + AVG_LOG2;
   localparam int WPW        = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int FW         = AVG_LOG2 + 1;
   localparam logic [FW-1:0]  N_F   = FW'(N);
   localparam logic [WPW-1:0] WP_MX = WPW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FIRE, S_WAIT, S_CAPT, S_HOLD
   } state_t;

   state_t state, state_nx;

   logic           ready_q;
   logic [31:0]    period_cnt;
   logic [31:0]    resp_cnt;
   logic [7:0]     win [N];
   logic [SW-1:0]  sum;
   logic [FW-1:0]  fill;
   logic [WPW-1:0] wp;

   logic           rise;
   logic           push;
   logic [7:0]     sample;
   logic [SW-1:0]  sum_nx;
   logic [FW-1:0]  fill_nx;

   assign rise    = ~ready_q & drv_ready;
   assign push    = (state == S_CAPT) && (drv_distance != 8'd0);
   assign sum_nx  = sum - SW'(win[wp]) + SW'(sample);
   assign fill_nx = (fill == N_F) ? fill : fill + 1'b1;

`ifdef SONAR_SAMPLER_MEDIAN3_EN
   logic [7:0] med_a;
   logic [7:0] med_b;
   logic [1:0] med_n;

   function automatic logic [7:0] med3(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic [7:0] c
   );
      logic [7:0] lo, hi, m;
      lo  = (a < b) ? a : b;
      hi  = (a < b) ? b : a;
      m   = (hi < c) ? hi : c;
      return (lo > m) ? lo : m;
   endfunction

   assign sample = (med_n == 2'd2) ?
                   med3(med_b, med_a, drv_distance) : drv_distance;

   // history of the last two nonzero raw samples feeding the median
   always_ff @(posedge clk) begin
      if (rst) begin
         med_a <= '0;
         med_b <= '0;
         med_n <= '0;
      end else if (push) begin
         med_b <= med_a;
         med_a <= drv_distance;
         if (med_n != 2'd2) med_n <= med_n + 1'b1;
      end
   end
`else
   assign sample = drv_distance;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // next-state: fire, wait for a fresh ready rise, capture, hold off
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (enable) state_nx = S_FIRE;
         S_FIRE: state_nx = S_WAIT;
         S_WAIT: begin
            if (rise)                 state_nx = S_CAPT;
            else if (resp_cnt == '0)  state_nx = S_HOLD;
         end
         S_CAPT: state_nx = S_HOLD;
         S_HOLD: begin
            if (!enable)                state_nx = S_IDLE;
            else if (period_cnt == '0)  state_nx = S_FIRE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // trigger request is asserted for the single FIRE cycle
   always_comb begin
      measure = 1'b0;
      if (state == S_FIRE) measure = 1'b1;
   end

   // counters, capture, window and averaged output
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q       <= 1'b0;
         period_cnt    <= '0;
         resp_cnt      <= '0;
         fault         <= 1'b0;
         last_distance <= '0;
         avg_distance  <= '0;
         avg_valid     <= 1'b0;
         no_echo       <= 1'b0;
         sum           <= '0;
         fill          <= '0;
         wp            <= '0;
         for (int i = 0; i < N; i++) win[i] <= '0;
      end else begin
         ready_q   <= drv_ready;
         avg_valid <= 1'b0;
         no_echo   <= 1'b0;
         if (state == S_FIRE) begin
            period_cnt <= 32'(PERIOD_CYC - 1);
            resp_cnt   <= 32'(RESP_CYC - 1);
         end else if (state != S_IDLE && period_cnt != '0) begin
            period_cnt <= period_cnt - 1'b1;
         end
         if (state == S_WAIT && !rise) begin
            if (resp_cnt == '0) fault    <= 1'b1;
            else                resp_cnt <= resp_cnt - 1'b1;
         end
         if (state == S_CAPT) begin
            last_distance <= drv_distance;
            if (drv_distance == 8'd0) no_echo <= 1'b1;
         end
         if (push) begin
            sum     <= sum_nx;
            win[wp] <= sample;
            wp      <= (wp == WP_MX) ? '0 : wp + 1'b1;
            fill    <= fill_nx;
            if (fill_nx == N_F) begin
               avg_distance <= 8'(sum_nx >> AVG_LOG2);
               avg_valid    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sonar_sampler.sv
// tb_sonar_sampler: directed checks of period, averaging, timeout, no-echo,
// stale ready, disable and pass-through / median behaviour.
`timescale 1ns/1ps
module tb_sonar_sampler;

`ifdef SONAR_SAMPLER_MEDIAN3_EN
   localparam bit MED = 1'b1;
`else
   localparam bit MED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       drv_ready = 1'b0;
   logic [7:0] drv_distance = 8'd0;

   logic       measure, avg_valid, no_echo, fault;
   logic [7:0] last_distance, avg_distance;
   logic       p_measure, p_avg_valid, p_no_echo, p_fault;
   logic [7:0] p_last, p_avg;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int nmeas = 0;
   int nne = 0;

   sonar_sampler #(
      .FREQ(100_000), .PERIOD_MS(1), .RESP_TIMEOUT_MS(0.5), .AVG_LOG2(2)
   ) u_dut (
      .clk(clk), .rst(rst), .enable(enable), .measure(measure),
      .drv_ready(drv_ready), .drv_distance(drv_distance),
      .last_distance(last_distance), .avg_distance(avg_distance),
      .avg_valid(avg_valid), .no_echo(no_echo), .fault(fault)
   );

   sonar_sampler #(
      .FREQ(100_000), .PERIOD_MS(1), .RESP_TIMEOUT_MS(0.5), .AVG_LOG2(0)
   ) u_pt (
      .clk(clk), .rst(rst), .enable(enable), .measure(p_measure),
      .drv_ready(drv_ready), .drv_distance(drv_distance),
      .last_distance(p_last), .avg_distance(p_avg),
      .avg_valid(p_avg_valid), .no_echo(p_no_echo), .fault(p_fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (measure) nmeas <= nmeas + 1;
      if (no_echo) nne <= nne + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_meas(output int mc);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!measure && n < 300);
      if (!measure) check("meas_wait", 0, 1);
      mc = cyc;
   endtask

   // driver model: drop ready on trigger, present result dly cycles later
   task automatic respond(input logic [7:0] d, input int dly, output int mc);
      wait_meas(mc);
      drv_ready = 1'b0;
      repeat (dly) @(negedge clk);
      drv_distance = d;
      drv_ready = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic restart();
      rst = 1'b1;
      enable = 1'b0;
      drv_ready = 1'b0;
      drv_distance = 8'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int m1, m2, e, n, fc, nb;
      repeat (3) @(negedge clk);
      check("rst_outs", {measure, last_distance, avg_distance,
                         avg_valid, no_echo, fault}, 0);
      check("rst_pt", {p_measure, p_last, p_avg,
                       p_avg_valid, p_no_echo, p_fault}, 0);
      rst = 1'b0;
      @(negedge clk);

      // averaging and period
      e = cyc;
      enable = 1'b1;
      respond(8'd10, 20, m1);
      check("en_to_meas", m1 - e + 1, 2);
      check("s1_last", last_distance, 10);
      check("s1_novalid", avg_valid, 0);
      respond(8'd20, 20, m2);
      check("period", m2 - m1, 101);
      check("s2_novalid", avg_valid, 0);
      respond(8'd30, 20, m1);
      check("s3_novalid", avg_valid, 0);
      respond(8'd40, 20, m1);
      check("s4_avg", {avg_valid, avg_distance},
            {1'b1, MED ? 8'd20 : 8'd25});
      respond(8'd50, 20, m1);
      check("s5_avg", {avg_valid, avg_distance},
            {1'b1, MED ? 8'd27 : 8'd35});
      check("s5_last", last_distance, 50);

      // no echo
      restart();
      nb = nne;
      enable = 1'b1;
      respond(8'd40, 20, m1);
      respond(8'd0, 20, m1);
      check("ne_pulse", no_echo, 1);
      check("ne_last", last_distance, 0);
      respond(8'd40, 20, m1);
      respond(8'd40, 20, m1);
      check("ne_novalid", avg_valid, 0);
      respond(8'd40, 20, m1);
      check("ne_avg", {avg_valid, avg_distance}, {1'b1, 8'd40});
      check("ne_count", nne - nb, 1);

      // response timeout
      restart();
      enable = 1'b1;
      wait_meas(m1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fault && n < 100);
      if (!fault) check("fault_wait", 0, 1);
      fc = cyc;
      check("fault_lat", fc - m1, 51);
      wait_meas(m2);
      check("fault_period", m2 - m1, 101);
      check("fault_sticky", fault, 1);
      rst = 1'b1;
      @(negedge clk);
      check("fault_clr", fault, 0);

      // stale ready and disable during a measurement
      restart();
      drv_distance = 8'd99;
      drv_ready = 1'b1;
      @(negedge clk);
      enable = 1'b1;
      wait_meas(m1);
      repeat (2) @(negedge clk);
      drv_ready = 1'b0;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      drv_distance = 8'd55;
      drv_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("stale_last", last_distance, 55);
      nb = nmeas;
      repeat (150) @(negedge clk);
      check("no_rearm", nmeas - nb, 0);
      e = cyc;
      enable = 1'b1;
      wait_meas(m1);
      check("reidle", m1 - e + 1, 2);

      // pass-through window and median prefilter
      restart();
      enable = 1'b1;
      respond(8'd10, 20, m1);
      check("pt_1", {p_avg_valid, p_avg}, {1'b1, 8'd10});
      respond(8'd200, 20, m1);
      check("pt_2", {p_avg_valid, p_avg}, {1'b1, 8'd200});
      respond(8'd12, 20, m1);
      check("pt_3", {p_avg_valid, p_avg}, {1'b1, 8'd12});
      respond(8'd14, 20, m1);
      check("pt_4", {p_avg_valid, p_avg}, {1'b1, 8'd14});
      respond(8'd100, 20, m1);
      check("pt_5", {p_avg_valid, p_avg},
            {1'b1, MED ? 8'd14 : 8'd100});
      check("pt_raw", p_last, 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
